vga_timing: RTL and testbench
=============================

Name: vga_timing

Overview:
- VGA raster timing generator for the display path.
- Sits directly downstream of the pixel-clock divider and is clocked by the divided pixel clock (25 MHz from 100 MHz).
- Produces hsync/vsync, active-video flag, current pixel coordinates and frame/line strobes for the pixel renderer.
- Default timing: 640x480@60, 800x525 total.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- CNT_W, 10, counter/coordinate width (must hold H_TOTAL-1 and V_TOTAL-1)

Ports:
- clk  in  1  pixel clock (driven by divider output clk_vga)
- rst  in  1  synchronous active-high reset
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high while (x,y) is inside the visible area
- x  out  CNT_W  horizontal counter value
- y  out  CNT_W  vertical counter value
- line_end  out  1  one-cycle pulse on the last pixel of every line
- frame_start  out  1  one-cycle pulse at x=0,y=0

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counters:
  - h_cnt increments every clk and wraps H_TOTAL-1 -> 0.
  - v_cnt increments only when h_cnt = H_TOTAL-1, and wraps V_TOTAL-1 -> 0 on that same cycle.
- Reset values:
  - h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1, so the first cycle after rst deasserts is (0,0).
  - Outputs during reset: hsync=1, vsync=1, video_on=0, line_end=1, frame_start=0, x=799, y=524.
- Output timing: all outputs are registers computed from next-state counter values, so they align exactly with x/y on the same cycle (zero latency relative to the counters).
- Decode rules:
  - x = h_cnt, y = v_cnt.
  - hsync = 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync = 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
    - vsync is a function of v_cnt only, so it changes at line boundaries.
  - video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - line_end = (h_cnt == H_TOTAL-1).
  - frame_start = (h_cnt == 0) && (v_cnt == 0).
- Boundary conditions:
  - At (799,524) the next cycle is (0,0).
  - line_end and frame_start are never high together.
- Reset mid-frame: counters jump to the reset values on the next edge with no partial sync pulse extension; hsync/vsync go inactive immediately.
- Arithmetic: unsigned comparisons only; CNT_W-bit counters never exceed TOTAL-1.

Optional Feature:
- Macro: VGA_OUT_REG_EN.
- Defined:
  - hsync, vsync and video_on get one extra register stage.
  - x and y are not delayed.
  - Effect: sync/blank lag the coordinates by exactly one cycle, aligning them with pixel data returned by a 1-cycle-latency memory addressed by x/y.
  - Reset value of each delayed stage equals the undelayed reset value.
- Undefined: all outputs aligned as described above.

Decomposition:
- Package vga_pkg holds:
  - default timing constants (H_/V_ ACTIVE, FP, SYNC, BP);
  - derived H_TOTAL/V_TOTAL;
  - CNT_W.
- One natural sub-module: vga_wrap_cnt, a parameterised modulo-N counter with enable, synchronous reset-to-N-1 and a wrap-pulse output.
  - Instantiated twice: horizontal counter always enabled; vertical counter enabled by the horizontal wrap.

Test Plan:
- Reset release: hold rst 3 cycles, release. Required: first post-reset cycle x=0, y=0, frame_start=1, video_on=1, hsync=1, vsync=1.
- Horizontal timing: run one line.
  - hsync low for exactly 96 cycles, at x=656..751.
  - video_on high for x=0..639.
  - line_end high only at x=799.
- Vertical timing: run one full frame (420000 cycles).
  - vsync low for exactly 2 lines (y=490,491, 1600 cycles).
  - y wraps 524->0 on the cycle after x=799,y=524.
  - frame_start period is exactly 420000 cycles.
- Mid-frame reset: assert rst at x=700 (inside hsync), y=300. Required: next cycle hsync=1, x=799, y=524; after release, frame restarts at (0,0).
- Active-area count: count video_on cycles over one frame. Required: exactly 307200.
- With VGA_OUT_REG_EN: hsync falls on the cycle after x=656; video_on drops on the cycle after x=640; x/y timing unchanged.

Source files
------------

// File: rtl/vga_pkg.sv
// Default 640x480@60 raster timing constants and shared types for vga_timing.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned CNT_W    = 10;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } vga_sync_t;

  localparam vga_sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};

endpackage

// File: rtl/vga_wrap_cnt.sv
// Modulo-N counter with enable; synchronous reset loads N-1 so the first enabled step lands on 0.
module vga_wrap_cnt #(
  parameter int unsigned N = 800,
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  always_comb begin
    cnt_nxt = cnt;
    wrap    = en && (cnt == LAST);
    if (en) cnt_nxt = (cnt == LAST) ? '0 : cnt + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= LAST;
    else     cnt <= cnt_nxt;
  end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: counters plus registered sync/blank/strobe decode.
// Define VGA_OUT_REG_EN to delay hsync/vsync/video_on by one cycle relative to x/y.
module vga_timing #(
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter int unsigned CNT_W    = vga_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_end,
  output logic             frame_start
);

  import vga_pkg::*;

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);

  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic             h_wrap, v_wrap;
  vga_sync_t        sync_d, sync_q;

  vga_wrap_cnt #(.N(H_TOT), .W(CNT_W)) u_h_cnt (
    .clk     (clk),
    .rst     (rst),
    .en      (1'b1),
    .cnt     (x),
    .cnt_nxt (h_nxt),
    .wrap    (h_wrap)
  );

  vga_wrap_cnt #(.N(V_TOT), .W(CNT_W)) u_v_cnt (
    .clk     (clk),
    .rst     (rst),
    .en      (h_wrap),
    .cnt     (y),
    .cnt_nxt (v_nxt),
    .wrap    (v_wrap)
  );

  // Decode the next counter values so the registered flags line up with x/y.
  always_comb begin
    sync_d.hsync    = !((h_nxt >= HS_BEG) && (h_nxt < HS_END));
    sync_d.vsync    = !((v_nxt >= VS_BEG) && (v_nxt < VS_END));
    sync_d.video_on = (h_nxt < H_VIS) && (v_nxt < V_VIS);
  end

  // A vertical wrap means the next position is (0,0), hence frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= SYNC_IDLE;
      line_end    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      line_end    <= (h_nxt == H_LAST);
      frame_start <= v_wrap;
    end
  end

`ifdef VGA_OUT_REG_EN
  vga_sync_t sync_o;

  always_ff @(posedge clk) begin
    if (rst) sync_o <= SYNC_IDLE;
    else     sync_o <= sync_q;
  end

  assign hsync    = sync_o.hsync;
  assign vsync    = sync_o.vsync;
  assign video_on = sync_o.video_on;
`else
  assign hsync    = sync_q.hsync;
  assign vsync    = sync_q.vsync;
  assign video_on = sync_q.video_on;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: default 640x480 timing over two lines plus a reduced-timing instance for whole frames.
module tb_vga_timing;

`ifdef VGA_OUT_REG_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_d, rst_s;
  logic       d_hs, d_vs, d_vo, d_le, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_hs, s_vs, s_vo, s_le, s_fs;
  logic [9:0] s_x, s_y;

  int n_cmp = 0;
  int n_err = 0;

  vga_timing u_dut_d (
    .clk(clk), .rst(rst_d), .hsync(d_hs), .vsync(d_vs), .video_on(d_vo),
    .x(d_x), .y(d_y), .line_end(d_le), .frame_start(d_fs)
  );

  // Small raster: 16 x 11 total, active 8 x 6, hsync x=10..12, vsync y=7..8.
  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .CNT_W(10)
  ) u_dut_s (
    .clk(clk), .rst(rst_s), .hsync(s_hs), .vsync(s_vs), .video_on(s_vo),
    .x(s_x), .y(s_y), .line_end(s_le), .frame_start(s_fs)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int hs_cnt, hs_first, hs_last, vo_cnt, vo_fall, vo_prev, le_cnt, le_x, fs_cnt, seq_err;
    int vs_cnt, vs_first_x, vs_first_y, both_cnt, ex, ey;

    rst_d = 1'b1;
    rst_s = 1'b1;
    repeat (3) step();

    chk("rst_hsync", d_hs, 1);
    chk("rst_vsync", d_vs, 1);
    chk("rst_video_on", d_vo, 0);
    chk("rst_line_end", d_le, 1);
    chk("rst_frame_start", d_fs, 0);
    chk("rst_x", d_x, 799);
    chk("rst_y", d_y, 524);

    rst_d = 1'b0;
    step();
    chk("rel_x", d_x, 0);
    chk("rel_y", d_y, 0);
    chk("rel_frame_start", d_fs, 1);
    chk("rel_video_on", d_vo, (LAG == 0) ? 1 : 0);
    chk("rel_hsync", d_hs, 1);
    chk("rel_vsync", d_vs, 1);
    chk("rel_line_end", d_le, 0);

    repeat (800) step();
    chk("line1_x", d_x, 0);
    chk("line1_y", d_y, 1);

    // Measure line y=1 in full.
    hs_cnt = 0; hs_first = -1; hs_last = -1; vo_cnt = 0; vo_fall = -1; vo_prev = 0;
    le_cnt = 0; le_x = -1; fs_cnt = 0; seq_err = 0;
    for (int i = 0; i < 800; i++) begin
      if (d_x !== 10'(i) || d_y !== 10'd1) seq_err++;
      if (d_hs === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
      if (d_vo === 1'b1) vo_cnt++;
      if (vo_prev == 1 && d_vo === 1'b0 && vo_fall < 0) vo_fall = i;
      vo_prev = (d_vo === 1'b1) ? 1 : 0;
      if (d_le === 1'b1) begin
        le_cnt++;
        le_x = i;
      end
      if (d_fs === 1'b1) fs_cnt++;
      step();
    end
    chk("line_seq_err", seq_err, 0);
    chk("hsync_low_cycles", hs_cnt, 96);
    chk("hsync_first_low_x", hs_first, 656 + LAG);
    chk("hsync_last_low_x", hs_last, 751 + LAG);
    chk("video_on_cycles", vo_cnt, 640);
    chk("video_on_fall_x", vo_fall, 640 + LAG);
    chk("line_end_count", le_cnt, 1);
    chk("line_end_x", le_x, 799);
    chk("frame_start_in_line1", fs_cnt, 0);
    chk("line2_y", d_y, 2);

    // Mid-line reset inside the hsync pulse.
    repeat (700) step();
    chk("mid_x", d_x, 700);
    chk("mid_hsync_low", d_hs, 0);
    rst_d = 1'b1;
    step();
    chk("mid_rst_hsync", d_hs, 1);
    chk("mid_rst_x", d_x, 799);
    chk("mid_rst_y", d_y, 524);
    chk("mid_rst_video_on", d_vo, 0);
    rst_d = 1'b0;
    step();
    chk("mid_rel_x", d_x, 0);
    chk("mid_rel_y", d_y, 0);
    chk("mid_rel_frame_start", d_fs, 1);

    // Small raster: one complete frame from (0,0).
    rst_s = 1'b1;
    step();
    rst_s = 1'b0;
    step();
    chk("s_start_x", s_x, 0);
    chk("s_start_y", s_y, 0);
    vs_cnt = 0; vs_first_x = -1; vs_first_y = -1; vo_cnt = 0; le_cnt = 0; fs_cnt = 0;
    both_cnt = 0; seq_err = 0; hs_cnt = 0; ex = 0; ey = 0;
    for (int i = 0; i < 176; i++) begin
      if (s_x !== 10'(ex) || s_y !== 10'(ey)) seq_err++;
      if (s_vs === 1'b0) begin
        vs_cnt++;
        if (vs_first_y < 0) begin
          vs_first_x = ex;
          vs_first_y = ey;
        end
      end
      if (s_hs === 1'b0) hs_cnt++;
      if (s_vo === 1'b1) vo_cnt++;
      if (s_le === 1'b1) le_cnt++;
      if (s_fs === 1'b1) fs_cnt++;
      if (s_le === 1'b1 && s_fs === 1'b1) both_cnt++;
      step();
      if (ex == 15) begin
        ex = 0;
        ey = (ey == 10) ? 0 : ey + 1;
      end else begin
        ex++;
      end
    end
    chk("s_seq_err", seq_err, 0);
    chk("s_vsync_low_cycles", vs_cnt, 32);
    chk("s_vsync_first_y", vs_first_y, 7);
    chk("s_vsync_first_x", vs_first_x, LAG);
    chk("s_hsync_low_cycles", hs_cnt, 33);
    chk("s_active_cycles", vo_cnt, 48);
    chk("s_line_end_count", le_cnt, 11);
    chk("s_frame_start_count", fs_cnt, 1);
    chk("s_le_fs_overlap", both_cnt, 0);
    chk("s_wrap_x", s_x, 0);
    chk("s_wrap_y", s_y, 0);
    chk("s_period_frame_start", s_fs, 1);

    // Small raster: reset at (11,4), inside hsync.
    repeat (75) step();
    chk("s_mid_x", s_x, 11);
    chk("s_mid_y", s_y, 4);
    chk("s_mid_hsync_low", s_hs, 0);
    rst_s = 1'b1;
    step();
    chk("s_mid_rst_hsync", s_hs, 1);
    chk("s_mid_rst_vsync", s_vs, 1);
    chk("s_mid_rst_x", s_x, 15);
    chk("s_mid_rst_y", s_y, 10);
    rst_s = 1'b0;
    step();
    chk("s_mid_rel_x", s_x, 0);
    chk("s_mid_rel_y", s_y, 0);
    chk("s_mid_rel_frame_start", s_fs, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
